branch_target_buffer_sa: RTL and testbench
==========================================

# branch_target_buffer_sa

Parametrised set-associative branch target buffer with per-entry 2-bit direction counters, serving FETCH_PORTS parallel lookups per cycle and one commit-side update per cycle. Sits in the fetch stage beside the I-cache: lookups are issued with the fetch PC group, results return one cycle later in step with the cache data, and the commit-side branch resolution unit drives updates. It generalises the earlier direct-mapped, two-port table with configurable depth, associativity, port count and target width, plus three additions: replacement, a reset-time valid-clear sweep and registered (BRAM-friendly) reads.

## Interface
- SETS, 128: number of sets; power of two, at least 2. IDX_W = log2(SETS).
- WAYS, 2: associativity; one of 1, 2 or 4.
- FETCH_PORTS, 2: number of parallel lookup ports, 1..4.
- TARGET_W, 32: target address width.
- TYPE_W, 2: branch-type field width.
- Derived: TAG_W = 32 - IDX_W - 2.
- Address mapping: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Ports (clock and reset first):
- clk  in  1  the block's single clock.
- rst  in  1  synchronous reset, active-high.
- ready  out  1  high once the init sweep is done.
- lkp_en  in  FETCH_PORTS  per-port lookup request.
- lkp_pc  in  FETCH_PORTS*32  per-port PC, packed; port p is at [32p+31:32p].
- rsp_valid  out  FETCH_PORTS  registered copy of lkp_en & ready.
- rsp_hit  out  FETCH_PORTS  tag match on a valid entry.
- rsp_taken  out  FETCH_PORTS  MSB of the matching entry's counter; 0 on a miss.
- rsp_type  out  FETCH_PORTS*TYPE_W  stored type; 0 on a miss.
- rsp_target  out  FETCH_PORTS*TARGET_W  stored target; 0 on a miss.
- upd_en  in  1  an update is present this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_type  in  TYPE_W  resolved branch type.
- upd_target  in  TARGET_W  resolved target; the value 0 means invalidate.

## Operation
- Per-entry state: valid, tag, target, type, 2-bit counter. Per-set state: round-robin victim pointer, log2(WAYS) bits wide (absent when WAYS = 1).
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
  - Taken: saturating +1.
  - Not taken: saturating -1.
  - Prediction is counter[1].
- FSM states: INIT and RUN.
  - rst → INIT with sweep counter = 0.
  - INIT: each cycle clears valid for every way of set[sweep counter] and clears that set's victim pointer, then increments the counter. After clearing set SETS-1 → RUN.
  - ready = (state == RUN).
- rst asserted in any state, including mid-sweep, restarts INIT from set 0.
- During INIT:
  - Updates are dropped.
  - rsp_valid = 0.
- Lookup (RUN): all ways of set[index] are compared against the tag; at most one way can match. Ports are independent; several ports may read the same set.
- Update hit (RUN):
  - Counter steps as above.
  - When upd_taken = 1, target and type are overwritten.
  - When upd_target = 0, valid is cleared instead.
  - The victim pointer is unchanged.
- Update miss (RUN):
  - Allocation happens only when upd_taken = 1 and upd_target ≠ 0; otherwise nothing changes.
  - Victim choice: the lowest-index invalid way; when no way is invalid, the way named by the victim pointer, and the pointer then increments modulo WAYS.
  - The allocated entry gets valid = 1, the tag, target and type, and counter = WT (10).
- Update and lookup to the same set in the same cycle: the lookup returns the contents from before the write (read-first). No bypass.

## Timing
- Lookup latency: 1 cycle. Inputs sampled at edge N; rsp_* valid after edge N+1 and held until the next edge.
- Update: written at the edge that samples upd_en; visible to lookups sampled at the next edge.
- Init sweep: SETS cycles. ready rises on the first cycle after the edge that clears set SETS-1.
- Reset values: ready = 0, and rsp_valid, rsp_hit, rsp_taken, rsp_type, rsp_target are all 0. Table contents are undefined until the sweep clears them.
- No back-pressure: every request is accepted every cycle.

## Structure
- Shared defines package holds:
  - counter encodings SNT, WNT, WT, ST;
  - the FSM state constants;
  - the branch-type codes already used by the commit-side branch info bus.
- One sub-module, btb_way_array: a single way of storage (tag, target, type, counter, valid) with FETCH_PORTS synchronous read ports and one write port. It is instantiated WAYS times. Victim pointers, hit/way select and the FSM live in the top level.

## Test plan
- Reset sweep, SETS=128: rst high for 1 cycle → ready stays 0 for exactly 128 cycles then goes to 1; all lookups and updates are ignored meanwhile; the first lookup afterwards has rsp_hit = 0.
- Allocate and hit: update at pc 0x0040_0100, taken, target 0x0040_0200, type 1 → a lookup one cycle later returns hit = 1, taken = 1, target 0x0040_0200, type 1. A second port looking up 0x0040_0104 in the same cycle misses.
- Counter walk: starting from WT, apply not-taken, not-taken, not-taken → prediction goes 0, 0, 0 (WNT, SNT, SNT); two taken updates then return the prediction to 1.
- Replacement, WAYS=2: three taken updates to different tags in one set → ways 0 and 1 are filled first; the third evicts way 0 (pointer 0 → 1) and the first tag then misses.
- Same-cycle conflict: a lookup and an allocating update to the same set in one cycle → this cycle's response misses; a lookup in the next cycle hits.
- Invalidate and mid-sweep reset: an update hit with target 0 → the next lookup misses. rst asserted at sweep count 50 → ready stays low for a further full 128 cycles.

Source files
------------

// File: rtl/branch_target_buffer_sa_pkg.sv
// rtl/branch_target_buffer_sa_pkg.sv - shared encodings and helpers for the set-associative BTB
package branch_target_buffer_sa_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } btb_state_e;

    // Branch-type codes as carried on the commit-side branch info bus
    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_type_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ctr : ctr + 2'd1;
        end
        return (ctr == SNT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_target_buffer_sa_way_array.sv
// rtl/branch_target_buffer_sa_way_array.sv - one BTB way: registered fetch read ports, combinational update probe, one write port
module btb_way_array #(
    parameter int SETS        = 128,
    parameter int FETCH_PORTS = 2,
    parameter int TAG_W       = 23,
    parameter int TARGET_W    = 32,
    parameter int TYPE_W      = 2,
    parameter int IDX_W       = $clog2(SETS)
) (
    input  logic                            clk,
    input  logic [FETCH_PORTS*IDX_W-1:0]    rd_addr,
    output logic [FETCH_PORTS-1:0]          rd_valid,
    output logic [FETCH_PORTS*TAG_W-1:0]    rd_tag,
    output logic [FETCH_PORTS*TARGET_W-1:0] rd_target,
    output logic [FETCH_PORTS*TYPE_W-1:0]   rd_type,
    output logic [FETCH_PORTS-1:0]          rd_taken,
    input  logic [IDX_W-1:0]                pr_addr,
    output logic                            pr_valid,
    output logic [TAG_W-1:0]                pr_tag,
    output logic [TARGET_W-1:0]             pr_target,
    output logic [TYPE_W-1:0]               pr_type,
    output logic [1:0]                      pr_ctr,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_addr,
    input  logic                            wr_valid,
    input  logic [TAG_W-1:0]                wr_tag,
    input  logic [TARGET_W-1:0]             wr_target,
    input  logic [TYPE_W-1:0]               wr_type,
    input  logic [1:0]                      wr_ctr
);

    logic                valid_mem  [SETS];
    logic [TAG_W-1:0]    tag_mem    [SETS];
    logic [TARGET_W-1:0] target_mem [SETS];
    logic [TYPE_W-1:0]   type_mem   [SETS];
    logic [1:0]          ctr_mem    [SETS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_addr]  <= wr_valid;
            tag_mem[wr_addr]    <= wr_tag;
            target_mem[wr_addr] <= wr_target;
            type_mem[wr_addr]   <= wr_type;
            ctr_mem[wr_addr]    <= wr_ctr;
        end
    end

    // Fetch reads sample the pre-write contents at the same edge (read-first)
    always_ff @(posedge clk) begin
        for (int p = 0; p < FETCH_PORTS; p++) begin
            rd_valid[p]                       <= valid_mem[rd_addr[p*IDX_W +: IDX_W]];
            rd_tag[p*TAG_W +: TAG_W]          <= tag_mem[rd_addr[p*IDX_W +: IDX_W]];
            rd_target[p*TARGET_W +: TARGET_W] <= target_mem[rd_addr[p*IDX_W +: IDX_W]];
            rd_type[p*TYPE_W +: TYPE_W]       <= type_mem[rd_addr[p*IDX_W +: IDX_W]];
            rd_taken[p]                       <= ctr_mem[rd_addr[p*IDX_W +: IDX_W]][1];
        end
    end

    assign pr_valid  = valid_mem[pr_addr];
    assign pr_tag    = tag_mem[pr_addr];
    assign pr_target = target_mem[pr_addr];
    assign pr_type   = type_mem[pr_addr];
    assign pr_ctr    = ctr_mem[pr_addr];

endmodule

// File: rtl/branch_target_buffer_sa.sv
// rtl/branch_target_buffer_sa.sv - set-associative BTB with 2-bit counters, multi-port lookup and commit-side update
module branch_target_buffer_sa
    import branch_target_buffer_sa_pkg::*;
#(
    parameter int SETS        = 128,
    parameter int WAYS        = 2,
    parameter int FETCH_PORTS = 2,
    parameter int TARGET_W    = 32,
    parameter int TYPE_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            ready,
    input  logic [FETCH_PORTS-1:0]          lkp_en,
    input  logic [FETCH_PORTS*32-1:0]       lkp_pc,
    output logic [FETCH_PORTS-1:0]          rsp_valid,
    output logic [FETCH_PORTS-1:0]          rsp_hit,
    output logic [FETCH_PORTS-1:0]          rsp_taken,
    output logic [FETCH_PORTS*TYPE_W-1:0]   rsp_type,
    output logic [FETCH_PORTS*TARGET_W-1:0] rsp_target,
    input  logic                            upd_en,
    input  logic [31:0]                     upd_pc,
    input  logic                            upd_taken,
    input  logic [TYPE_W-1:0]               upd_type,
    input  logic [TARGET_W-1:0]             upd_target
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_state_e       state;
    logic [IDX_W-1:0] sweep;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            sweep <= '0;
            ready <= 1'b0;
        end else if (state == ST_INIT) begin
            sweep <= sweep + 1'b1;
            if (&sweep) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end
    end

    logic [IDX_W-1:0]    u_idx;
    logic [TAG_W-1:0]    u_tag;
    logic [1:0]          unused_pc_lo;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    always_comb begin
        unused_pc_lo = upd_pc[1:0];
        for (int p = 0; p < FETCH_PORTS; p++) begin
            unused_pc_lo = unused_pc_lo ^ lkp_pc[32*p +: 2];
        end
    end

    logic [FETCH_PORTS*IDX_W-1:0]    r_addr;
    logic [FETCH_PORTS-1:0]          r_valid  [WAYS];
    logic [FETCH_PORTS*TAG_W-1:0]    r_tag    [WAYS];
    logic [FETCH_PORTS*TARGET_W-1:0] r_target [WAYS];
    logic [FETCH_PORTS*TYPE_W-1:0]   r_type   [WAYS];
    logic [FETCH_PORTS-1:0]          r_taken  [WAYS];

    logic [WAYS-1:0]     p_valid;
    logic [TAG_W-1:0]    p_tag    [WAYS];
    logic [TARGET_W-1:0] p_target [WAYS];
    logic [TYPE_W-1:0]   p_type   [WAYS];
    logic [1:0]          p_ctr    [WAYS];

    logic [WAYS-1:0]     w_en;
    logic [IDX_W-1:0]    w_addr;
    logic                w_valid;
    logic [TARGET_W-1:0] w_target;
    logic [TYPE_W-1:0]   w_type;
    logic [1:0]          w_ctr;

    always_comb begin
        for (int p = 0; p < FETCH_PORTS; p++) begin
            r_addr[p*IDX_W +: IDX_W] = lkp_pc[32*p+2 +: IDX_W];
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way_array #(
            .SETS        (SETS),
            .FETCH_PORTS (FETCH_PORTS),
            .TAG_W       (TAG_W),
            .TARGET_W    (TARGET_W),
            .TYPE_W      (TYPE_W),
            .IDX_W       (IDX_W)
        ) u_way (
            .clk       (clk),
            .rd_addr   (r_addr),
            .rd_valid  (r_valid[w]),
            .rd_tag    (r_tag[w]),
            .rd_target (r_target[w]),
            .rd_type   (r_type[w]),
            .rd_taken  (r_taken[w]),
            .pr_addr   (u_idx),
            .pr_valid  (p_valid[w]),
            .pr_tag    (p_tag[w]),
            .pr_target (p_target[w]),
            .pr_type   (p_type[w]),
            .pr_ctr    (p_ctr[w]),
            .wr_en     (w_en[w]),
            .wr_addr   (w_addr),
            .wr_valid  (w_valid),
            .wr_tag    (u_tag),
            .wr_target (w_target),
            .wr_type   (w_type),
            .wr_ctr    (w_ctr)
        );
    end

    logic             sweeping;
    logic [WAY_W-1:0] vptr_cur;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             u_hit;
    logic             has_free;
    logic             ptr_adv;

    assign sweeping = !rst && (state == ST_INIT);

    always_comb begin
        w_en     = '0;
        w_addr   = u_idx;
        w_valid  = 1'b0;
        w_target = upd_target;
        w_type   = upd_type;
        w_ctr    = WT;
        ptr_adv  = 1'b0;
        u_hit    = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        victim   = vptr_cur;
        for (int w = 0; w < WAYS; w++) begin
            if (p_valid[w] && p_tag[w] == u_tag) begin
                u_hit   = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!p_valid[w] && !has_free) begin
                has_free = 1'b1;
                victim   = WAY_W'(w);
            end
        end
        if (sweeping) begin
            w_en   = '1;
            w_addr = sweep;
        end else if (!rst && state == ST_RUN && upd_en) begin
            if (u_hit) begin
                w_en[hit_way] = 1'b1;
                w_valid       = (upd_target != '0);
                w_ctr         = ctr_next(p_ctr[hit_way], upd_taken);
                if (!upd_taken) begin
                    w_target = p_target[hit_way];
                    w_type   = p_type[hit_way];
                end
            end else if (upd_taken && upd_target != '0) begin
                w_en[victim] = 1'b1;
                w_valid      = 1'b1;
                ptr_adv      = !has_free;
            end
        end
    end

    // Round-robin pointer only moves when a valid entry had to be evicted
    if (WAYS > 1) begin : g_vptr
        logic [WAY_W-1:0] vptr [SETS];
        always_ff @(posedge clk) begin
            if (sweeping) begin
                vptr[sweep] <= '0;
            end else if (ptr_adv) begin
                vptr[u_idx] <= vptr[u_idx] + 1'b1;
            end
        end
        assign vptr_cur = vptr[u_idx];
    end else begin : g_no_vptr
        assign vptr_cur = '0;
    end

    logic [FETCH_PORTS-1:0] valid_q;
    logic [TAG_W-1:0]       ltag_q [FETCH_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= lkp_en & {FETCH_PORTS{ready}};
        end
        for (int p = 0; p < FETCH_PORTS; p++) begin
            ltag_q[p] <= lkp_pc[32*p+IDX_W+2 +: TAG_W];
        end
    end

    assign rsp_valid = valid_q;

    always_comb begin
        rsp_hit    = '0;
        rsp_taken  = '0;
        rsp_type   = '0;
        rsp_target = '0;
        for (int p = 0; p < FETCH_PORTS; p++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (valid_q[p] && r_valid[w][p] && r_tag[w][p*TAG_W +: TAG_W] == ltag_q[p]) begin
                    rsp_hit[p]                         = 1'b1;
                    rsp_taken[p]                       = r_taken[w][p];
                    rsp_type[p*TYPE_W +: TYPE_W]       = r_type[w][p*TYPE_W +: TYPE_W];
                    rsp_target[p*TARGET_W +: TARGET_W] = r_target[w][p*TARGET_W +: TARGET_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// tb/tb_branch_target_buffer_sa.sv - randomized and directed checks of branch_target_buffer_sa against a behavioural model
module tb_branch_target_buffer_sa;

    localparam int SETS = 128;
    localparam int WAYS = 2;
    localparam int FP   = 2;
    localparam int TW   = 32;
    localparam int YW   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ready;
    logic [FP-1:0]    lkp_en = '0;
    logic [FP*32-1:0] lkp_pc = '0;
    logic [FP-1:0]    rsp_valid, rsp_hit, rsp_taken;
    logic [FP*YW-1:0] rsp_type;
    logic [FP*TW-1:0] rsp_target;
    logic             upd_en = 1'b0;
    logic [31:0]      upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic [YW-1:0]    upd_type = '0;
    logic [TW-1:0]    upd_target = '0;

    always #5 clk = ~clk;

    branch_target_buffer_sa #(
        .SETS(SETS), .WAYS(WAYS), .FETCH_PORTS(FP), .TARGET_W(TW), .TYPE_W(YW)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .lkp_en(lkp_en), .lkp_pc(lkp_pc),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_taken(rsp_taken),
        .rsp_type(rsp_type), .rsp_target(rsp_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_type(upd_type), .upd_target(upd_target)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain table of entries per set plus a rotating eviction choice
    bit        m_v   [SETS][WAYS];
    bit [22:0] m_tag [SETS][WAYS];
    bit [31:0] m_tgt [SETS][WAYS];
    bit [1:0]  m_ty  [SETS][WAYS];
    int        m_ct  [SETS][WAYS];
    int        m_vp  [SETS];
    bit        m_ready = 0;
    int        m_cnt   = 0;

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_vp[s] = 0;
            for (int w = 0; w < WAYS; w++) m_v[s][w] = 0;
        end
    endfunction

    function automatic void m_look(input bit [31:0] pc, output bit h, output bit tk,
                                   output bit [1:0] ty, output bit [31:0] tg);
        int idx = int'(pc[8:2]);
        h = 0; tk = 0; ty = 0; tg = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_v[idx][w] && m_tag[idx][w] == pc[31:9]) begin
                h = 1; tk = (m_ct[idx][w] >= 2); ty = m_ty[idx][w]; tg = m_tgt[idx][w];
            end
        end
    endfunction

    function automatic void m_update(input bit [31:0] pc, input bit taken,
                                     input bit [1:0] ty, input bit [31:0] tg);
        int idx = int'(pc[8:2]);
        int way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_v[idx][w] && m_tag[idx][w] == pc[31:9]) way = w;
        if (way >= 0) begin
            m_ct[idx][way] = taken ? ((m_ct[idx][way] < 3) ? m_ct[idx][way] + 1 : 3)
                                   : ((m_ct[idx][way] > 0) ? m_ct[idx][way] - 1 : 0);
            if (taken) begin
                m_tgt[idx][way] = tg;
                m_ty[idx][way]  = ty;
            end
            if (tg == 0) m_v[idx][way] = 0;
        end else if (taken && tg != 0) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_v[idx][w]) way = w;
            if (way < 0) begin
                way = m_vp[idx];
                m_vp[idx] = (m_vp[idx] + 1) % WAYS;
            end
            m_v[idx][way] = 1; m_tag[idx][way] = pc[31:9];
            m_tgt[idx][way] = tg; m_ty[idx][way] = ty; m_ct[idx][way] = 2;
        end
    endfunction

    task automatic step();
        bit h, tk;
        bit [1:0] ty;
        bit [31:0] tg;
        bit [FP-1:0] ev = '0, eh = '0, et = '0;
        bit [FP*YW-1:0] ey = '0;
        bit [FP*TW-1:0] eg = '0;
        for (int p = 0; p < FP; p++) begin
            if (lkp_en[p] && m_ready && !rst) begin
                ev[p] = 1;
                m_look(lkp_pc[32*p +: 32], h, tk, ty, tg);
                eh[p] = h; et[p] = tk; ey[YW*p +: YW] = ty; eg[TW*p +: TW] = tg;
            end
        end
        if (rst) begin
            m_ready = 0; m_cnt = 0; m_clear();
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == SETS) m_ready = 1;
        end else if (upd_en) begin
            m_update(upd_pc, upd_taken, upd_type, upd_target);
        end
        @(posedge clk);
        #1;
        chk("ready", 64'(ready), 64'(m_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rsp_hit", 64'(rsp_hit), 64'(eh));
        chk("rsp_taken", 64'(rsp_taken), 64'(et));
        chk("rsp_type", 64'(rsp_type), 64'(ey));
        chk("rsp_target", 64'(rsp_target), 64'(eg));
    endtask

    function automatic logic [31:0] rand_pc();
        logic [22:0] tag = 23'h100 + 23'($urandom_range(0, 4));
        logic [6:0]  idx = 7'($urandom_range(0, 2) * 5);
        return {tag, idx, 2'b00};
    endfunction

    task automatic rand_inputs();
        lkp_en     = FP'($urandom);
        for (int p = 0; p < FP; p++) lkp_pc[32*p +: 32] = rand_pc();
        upd_en     = 1'($urandom);
        upd_pc     = rand_pc();
        upd_taken  = ($urandom_range(0, 3) != 0);
        upd_type   = YW'($urandom);
        upd_target = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
    endtask

    task automatic idle();
        lkp_en = '0; upd_en = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [1:0] ty);
        idle();
        upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_type = ty;
        step();
        upd_en = 1'b0;
    endtask

    task automatic do_look(input logic [31:0] pc0, input logic [31:0] pc1);
        idle();
        lkp_en = 2'b11; lkp_pc = {pc1, pc0};
        step();
        lkp_en = '0;
    endtask

    int low_cnt;

    initial begin
        bit [0:4] walk_tk;
        bit [0:4] walk_exp;
        walk_tk  = 5'b00011;
        walk_exp = 5'b00001;

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            rand_inputs();
            step();
            if (i < SETS - 1) chk("sweep_ready_low", 64'(ready), 64'd0);
        end
        chk("sweep_ready_high", 64'(ready), 64'd1);

        do_look(32'h0040_0100, 32'h0012_3450);
        chk("first_lookup_miss", 64'(rsp_hit), 64'd0);

        do_upd(32'h0040_0100, 1'b1, 32'h0040_0200, 2'd1);
        do_look(32'h0040_0100, 32'h0040_0104);
        chk("alloc_hit", 64'(rsp_hit), 64'b01);
        chk("alloc_taken", 64'(rsp_taken[0]), 64'd1);
        chk("alloc_target", 64'(rsp_target[31:0]), 64'h0040_0200);
        chk("alloc_type", 64'(rsp_type[1:0]), 64'd1);

        for (int i = 0; i < 5; i++) begin
            do_upd(32'h0040_0100, walk_tk[i], 32'h0040_0200, 2'd1);
            do_look(32'h0040_0100, 32'h0040_0100);
            chk("counter_walk", 64'(rsp_taken[0]), 64'(walk_exp[i]));
        end

        do_upd(32'h0010_0040, 1'b1, 32'h0000_1000, 2'd0);
        do_upd(32'h0020_0040, 1'b1, 32'h0000_2000, 2'd2);
        do_upd(32'h0030_0040, 1'b1, 32'h0000_3000, 2'd3);
        do_look(32'h0010_0040, 32'h0020_0040);
        chk("repl_evict_way0", 64'(rsp_hit), 64'b10);
        do_look(32'h0030_0040, 32'h0030_0040);
        chk("repl_new_target", 64'(rsp_target[31:0]), 64'h0000_3000);

        idle();
        lkp_en = 2'b01; lkp_pc[31:0] = 32'h0040_0080;
        upd_en = 1'b1; upd_pc = 32'h0040_0080; upd_taken = 1'b1;
        upd_target = 32'h0000_4444; upd_type = 2'd2;
        step();
        chk("same_cycle_miss", 64'(rsp_hit[0]), 64'd0);
        do_look(32'h0040_0080, 32'h0040_0080);
        chk("next_cycle_hit", 64'(rsp_hit), 64'b11);

        do_upd(32'h0040_0080, 1'b1, 32'h0000_0000, 2'd0);
        do_look(32'h0040_0080, 32'h0040_0080);
        chk("invalidate_miss", 64'(rsp_hit), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rand_inputs();
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        low_cnt = 1;
        for (int i = 0; i < 300 && !ready; i++) begin
            rand_inputs();
            step();
            if (!ready) low_cnt++;
        end
        chk("midsweep_restart_len", 64'(low_cnt), 64'd128);

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
